// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants and types.
// conv1 produces a 22x22 map of 23-bit signed results. The 2x2 max-pool
// reduces that map to 11x11.
package cnn_pkg;

    localparam int CONV1_OUT_W   = 23;
    localparam int CONV1_OUT_DIM = 22;
    localparam int POOL1_OUT_DIM = 11;

    typedef logic signed [CONV1_OUT_W-1:0] conv_word_t;

endpackage : cnn_pkg

// File: rtl/conv1_maxpool_if.sv
// Streams around the conv1 max-pool stage.
//   conv side : conv_out_1 / valid_out_calc in, maxpool_ready back
//   pool side : pool_out / pool_valid / pool_last out, pool_ready back
// Modports:
//   slave  - pool stage view (consumes the conv stream, drives the pool stream)
//   master - environment view (drives the conv stream, consumes the pool stream)
interface conv1_maxpool_if #(
    parameter int DATA_W = 23
);

    logic signed [DATA_W-1:0] conv_out_1;
    logic                     valid_out_calc;
    logic                     maxpool_ready;
    logic signed [DATA_W-1:0] pool_out;
    logic                     pool_valid;
    logic                     pool_ready;
    logic                     pool_last;

    modport slave (
        input  conv_out_1, valid_out_calc, pool_ready,
        output maxpool_ready, pool_out, pool_valid, pool_last
    );

    modport master (
        output conv_out_1, valid_out_calc, pool_ready,
        input  maxpool_ready, pool_out, pool_valid, pool_last
    );

endinterface : conv1_maxpool_if

// File: rtl/pool_out_fifo.sv
// Output FIFO of the conv1 max-pool stage.
// Each entry holds a pooled value together with its last-window tag.
// The head entry is kept in a register, so it holds its last value when the
// FIFO is empty. A push and a pop on the same edge keep the count unchanged,
// and the pop takes the old head.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write one entry (caller never pushes when full)
//   pop_req           pop the head if one is present
//   head, head_valid  registered head entry / FIFO non-empty
//   count_next        occupancy after this edge's push/pop (for flow control)
//   full              FIFO holds DEPTH entries
module pool_out_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count_next,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] head_r;
    logic             head_valid_r;

    logic             pop_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic [CNT_W-1:0] remain_s;
    logic [WIDTH-1:0] head_next_s;

    // Circular pointer increment for a depth that need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Next pointers, occupancy and head entry
    always_comb begin
        pop_s         = pop_req && (count_r != CNT_W'(0));
        wr_ptr_next_s = push  ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        rd_ptr_next_s = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        remain_s      = pop_s ? (count_r - CNT_W'(1)) : count_r;
        count_next_s  = push  ? (remain_s + CNT_W'(1)) : remain_s;
        head_next_s   = head_r;
        if (count_next_s == CNT_W'(0)) begin
            head_next_s = head_r;
        end else if (remain_s == CNT_W'(0)) begin
            // Nothing older survives this edge: the new entry becomes head
            head_next_s = push_data;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, count and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            head_r       <= '0;
            head_valid_r <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            count_r      <= count_next_s;
            head_r       <= head_next_s;
            head_valid_r <= (count_next_s != CNT_W'(0));
        end
    end

    assign head       = head_r;
    assign head_valid = head_valid_r;
    assign count_next = count_next_s;
    assign full       = (count_r == CNT_W'(DEPTH));

endmodule : pool_out_fifo

// File: rtl/pool_out_fifo_chk.sv
// Checker for the pool output FIFO: a push into a full FIFO would silently
// drop a pooled value, so it must never happen.
// Ports: clk, rst, push (FIFO write), full (FIFO at capacity)
module pool_out_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule : pool_out_fifo_chk

// File: rtl/conv1_maxpool.sv
// 2x2 stride-2 max-pool on the conv1 result stream.
// The input is a raster-order conv map (conv_out_1 / valid_out_calc). The
// stage emits one pooled value per 2x2 window through a small FIFO. It returns
// maxpool_ready, which gates the conv pipeline.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       conv1_maxpool_if.slave (conv stream in, pool stream out)
// Build option:
//   CONV1_MAXPOOL_RELU_EN - when defined, negative pooled values are pushed
//   as 0 (ReLU fused after the pool).
module conv1_maxpool
    import cnn_pkg::*;
#(
    parameter int CONV_WIDTH  = CONV1_OUT_DIM,
    parameter int CONV_HEIGHT = CONV1_OUT_DIM,
    parameter int DATA_W      = CONV1_OUT_W,
    parameter int FIFO_DEPTH  = 4
) (
    input logic            clk,
    input logic            rst,
    conv1_maxpool_if.slave bus
);

    localparam int COL_W  = $clog2(CONV_WIDTH);
    localparam int ROW_W  = $clog2(CONV_HEIGHT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int HBUF_N = 2 ** (COL_W - 1);
    // Odd trailing column/row never pools, so the last window ends one earlier
    localparam int LAST_POOL_COL = (CONV_WIDTH / 2) * 2 - 1;
    localparam int LAST_POOL_ROW = (CONV_HEIGHT / 2) * 2 - 1;

    typedef logic signed [DATA_W-1:0] word_t;

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic             fresh_r;
    logic             ready_r;
    word_t            pair_r;
    word_t            rowbuf_r [HBUF_N];

    logic             consume_s;
    logic             push_s;
    logic             push_last_s;
    word_t            hmax_s;
    word_t            pooled_s;
    word_t            push_val_s;
    logic [DATA_W:0]  head_s;
    logic [CNT_W-1:0] count_next_s;
    logic             full_s;

    // Signed maximum over the full sample width; ties return the common value
    function automatic word_t smax(input word_t a, input word_t b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Sample consumption, pairing and pooled value
    always_comb begin
        // A held conv sample is only new if ready was high when conv advanced
        consume_s   = bus.valid_out_calc && fresh_r;
        hmax_s      = smax(pair_r, bus.conv_out_1);
        pooled_s    = smax(rowbuf_r[col_r[COL_W-1:1]], hmax_s);
        push_s      = consume_s && col_r[0] && row_r[0];
        push_last_s = (row_r == ROW_W'(LAST_POOL_ROW)) && (col_r == COL_W'(LAST_POOL_COL));
`ifdef CONV1_MAXPOOL_RELU_EN
        if (pooled_s[DATA_W-1]) begin
            push_val_s = '0;
        end else begin
            push_val_s = pooled_s;
        end
`else
        push_val_s  = pooled_s;
`endif
    end

    // Raster position, freshness and registered flow control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r   <= '0;
            row_r   <= '0;
            fresh_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            fresh_r <= ready_r;
            // Threshold leaves room for pushes already in flight when ready falls
            ready_r <= (count_next_s <= CNT_W'(FIFO_DEPTH - 2));
            if (consume_s) begin
                if (col_r == COL_W'(CONV_WIDTH - 1)) begin
                    col_r <= '0;
                    if (row_r == ROW_W'(CONV_HEIGHT - 1)) begin
                        row_r <= '0;
                    end else begin
                        row_r <= row_r + ROW_W'(1);
                    end
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
        end
    end

    // Pair register and half-row buffer of horizontal maxima
    always_ff @(posedge clk) begin
        if (consume_s) begin
            if (!col_r[0]) begin
                pair_r <= bus.conv_out_1;
            end else if (!row_r[0]) begin
                rowbuf_r[col_r[COL_W-1:1]] <= hmax_s;
            end
        end
    end

    pool_out_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_data  ({push_last_s, push_val_s}),
        .pop_req    (bus.pool_ready),
        .head       (head_s),
        .head_valid (bus.pool_valid),
        .count_next (count_next_s),
        .full       (full_s)
    );

`ifndef SYNTHESIS
    pool_out_fifo_chk u_fifo_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .full (full_s)
    );
`endif

    assign bus.pool_out      = head_s[DATA_W-1:0];
    assign bus.pool_last     = head_s[DATA_W];
    assign bus.maxpool_ready = ready_r;

endmodule : conv1_maxpool
